// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and decode output.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; the payload
// must hold while valid is high and ready is low. imem_rsp_valid and redirect_valid carry no ready.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instruction, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instruction, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single-outstanding memory requests,
// prefetch FIFO toward decode, and redirect handling that flushes and drops stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      bus,
  output logic [1:0]        o_dbg_state
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_credit;
  logic        w_credit_after_push;
  logic        w_push;
  logic        w_pop;
  logic        w_instr_valid;

  assign w_redirect    = bus.redirect_valid;
  assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

  // Nothing is outstanding in IDLE, and in WAIT the outstanding request becomes the pushed entry,
  // so both credit tests reduce to the registered FIFO count.
  assign w_credit            = r_count < CW'(FIFO_DEPTH);
  assign w_credit_after_push = (r_count + CW'(1)) < CW'(FIFO_DEPTH);

  assign w_push        = (r_state == WAIT) && bus.imem_rsp_valid && !w_redirect;
  assign w_instr_valid = (r_count != '0) && !w_redirect;
  assign w_pop         = w_instr_valid && bus.instr_ready;

  assign bus.imem_req_valid = (r_state == REQ);
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.instr_valid    = w_instr_valid;
  assign bus.instruction    = r_fifo_data[r_rd_ptr];
  assign bus.instr_pc       = r_fifo_pc[r_rd_ptr];
  assign o_dbg_state        = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else if (w_redirect) begin
      // A request accepted in the redirect cycle is still outstanding, so its response must be dropped.
      r_fetch_pc <= w_redirect_pc;
      case (r_state)
        IDLE:       r_state <= REQ;
        REQ:        r_state <= bus.imem_req_ready ? DROP : REQ;
        WAIT, DROP: r_state <= bus.imem_rsp_valid ? REQ : DROP;
        default:    r_state <= IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: if (w_credit) r_state <= REQ;
        REQ: begin
          if (bus.imem_req_ready) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_req_pc   <= r_fetch_pc;
            r_state    <= WAIT;
          end
        end
        WAIT: if (bus.imem_rsp_valid) r_state <= w_credit_after_push ? REQ : IDLE;
        DROP: if (bus.imem_rsp_valid) r_state <= REQ;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bus.imem_rsp_data;
        r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-vector table, directed redirect/reset sequences, a wrap-around
// instance, and randomized traffic checked against a PC-stream reference model.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int          DEPTH   = 2;
  localparam logic [31:0] KEY     = 32'hA5A5_A5A5;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_unit_if bus2();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );
  fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus2), .o_dbg_state(dbg_state2)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] got2_pc_q[$];
  logic [31:0] got2_data_q[$];

  // memory models: main instance has variable latency, wrap instance answers next cycle
  bit          mem_busy;
  int          mem_cnt;
  int          lat;
  logic [31:0] mem_addr;
  bit          b_pend;
  logic [31:0] b_addr;

  // reference model: next PC decode must see, next address memory must see, credit bookkeeping
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  int          m_issued;
  int          m_delivered;

  typedef struct {
    logic        req_ready;
    logic        instr_ready;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_instr_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t t1[10];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = 32'h0;
    m_fetch     = 32'h0;
    m_issued    = 0;
    m_delivered = 0;
    got_q.delete();
    acc_q.delete();
    got2_pc_q.delete();
    got2_data_q.delete();
  endtask

  task automatic monitor();
    if (!rst) begin
      if (bus.redirect_valid) check32("no_valid_on_redirect", 32'(bus.instr_valid), 32'd0);
      if (bus.instr_valid && bus.instr_ready) begin
        check32("instr_pc", bus.instr_pc, m_pc);
        check32("instruction", bus.instruction, m_pc ^ KEY);
        got_q.push_back(bus.instr_pc);
        m_pc = m_pc + 32'd4;
        m_delivered++;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mem_busy = 1'b1;
        mem_cnt  = lat;
        mem_addr = bus.imem_req_addr;
        acc_q.push_back(bus.imem_req_addr);
        if (!bus.redirect_valid) begin
          check32("req_addr", bus.imem_req_addr, m_fetch);
          check32("credit", 32'(m_issued - m_delivered + 1 <= DEPTH), 32'd1);
          m_fetch = m_fetch + 32'd4;
          m_issued++;
        end
      end
      if (bus.redirect_valid) begin
        m_pc        = {bus.redirect_pc[31:2], 2'b00};
        m_fetch     = m_pc;
        m_issued    = 0;
        m_delivered = 0;
      end
      if (bus2.imem_req_valid) begin
        b_pend = 1'b1;
        b_addr = bus2.imem_req_addr;
      end
      if (bus2.instr_valid) begin
        got2_pc_q.push_back(bus2.instr_pc);
        got2_data_q.push_back(bus2.instruction);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample_edge();
    @(negedge clk);
    monitor();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_addr ^ KEY;
        mem_busy           = 1'b0;
      end
    end
    bus2.imem_rsp_valid = b_pend;
    bus2.imem_rsp_data  = b_addr ^ KEY;
    b_pend              = 1'b0;
  endtask

  task automatic tick();
    sample_edge();
    advance();
  endtask

  task automatic do_reset(input bit check_state);
    bus.imem_req_ready  = 1'b0;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = 32'h0;
    bus2.imem_rsp_valid = 1'b0;
    mem_busy = 1'b0;
    b_pend   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_state) begin
      check32("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check32("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      check32("rst_req_addr", bus.imem_req_addr, 32'h0);
      check32("rst_instruction", bus.instruction, 32'h0);
      check32("rst_instr_pc", bus.instr_pc, 32'h0);
      check32("rst_dbg_state", 32'(dbg_state), 32'd0);
      check32("rst_wrap_req_addr", bus2.imem_req_addr, WRAP_PC);
      check32("rst_wrap_dbg_state", 32'(dbg_state2), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_got(input string name, input int n, input int budget);
    int b;
    b = budget;
    while (got_q.size() < n && b > 0) begin
      tick();
      b--;
    end
    check32(name, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic compare_got(input string name);
    for (int i = 0; i < exp_q.size(); i++)
      check32($sformatf("%s_%0d", name, i), (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, exp_q[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    t1[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    t1[1] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    t1[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    t1[3] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0};
    t1[4] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    t1[5] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    t1[6] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    t1[7] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8};
    t1[8] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    t1[9] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

    lat = 1;
    bus2.imem_req_ready = 1'b1;
    bus2.instr_ready    = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.imem_rsp_data  = 32'h0;

    // sequential fetch, one instruction every two cycles
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      bus.imem_req_ready = t1[k].req_ready;
      bus.instr_ready    = t1[k].instr_ready;
      sample_edge();
      check32($sformatf("t1_req_valid_c%0d", k), 32'(bus.imem_req_valid), 32'(t1[k].exp_req_valid));
      if (t1[k].exp_req_valid)
        check32($sformatf("t1_req_addr_c%0d", k), bus.imem_req_addr, t1[k].exp_addr);
      check32($sformatf("t1_instr_valid_c%0d", k), 32'(bus.instr_valid), 32'(t1[k].exp_instr_valid));
      if (t1[k].exp_instr_valid)
        check32($sformatf("t1_instr_pc_c%0d", k), bus.instr_pc, t1[k].exp_pc);
      advance();
    end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    compare_got("t1_order");

    // wrap-around instance ran alongside
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    check32("t5_count", 32'(got2_pc_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check32($sformatf("t5_pc_%0d", i), (i < got2_pc_q.size()) ? got2_pc_q[i] : 32'hxxxx_xxxx, exp_q[i]);
      check32($sformatf("t5_data_%0d", i), (i < got2_data_q.size()) ? got2_data_q[i] : 32'hxxxx_xxxx,
              exp_q[i] ^ KEY);
    end

    // decode stalled: fetch stops after DEPTH requests
    do_reset(1'b0);
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b0;
    repeat (20) tick();
    check32("t2_requests", 32'(acc_q.size()), 32'(DEPTH));
    sample_edge();
    check32("t2_req_idle", 32'(bus.imem_req_valid), 32'd0);
    advance();
    bus.instr_ready = 1'b1;
    wait_got("t2_timeout", 3, 40);
    exp_q = '{32'h0, 32'h4, 32'h8};
    compare_got("t2_order");
    check32("t2_resume_addr", (acc_q.size() > 2) ? acc_q[2] : 32'hxxxx_xxxx, 32'h8);

    // redirect while waiting for a slow response
    do_reset(1'b0);
    lat = 3;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    tick();
    tick();
    check32("t3_in_wait", 32'(acc_q.size()), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    tick();
    wait_got("t3_timeout", 1, 40);
    exp_q = '{32'h100};
    compare_got("t3_first");
    check32("t3_next_addr", (acc_q.size() > 1) ? acc_q[1] : 32'hxxxx_xxxx, 32'h100);

    // redirect coinciding with request acceptance, then with the response
    do_reset(1'b0);
    lat = 2;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    sample_edge();
    check32("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check32("t4_req_addr", bus.imem_req_addr, 32'h10);
    advance();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick();
    wait_got("t4_timeout", 2, 40);
    exp_q = '{32'h200, 32'h204};
    compare_got("t4_order");

    // asynchronous reset in WAIT with one buffered entry; late response must be ignored
    do_reset(1'b0);
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b0;
    tick();
    tick();
    lat = 5;
    tick();
    tick();
    #2;
    check32("t6_pre_valid", 32'(bus.instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    check32("t6_instr_valid_drop", 32'(bus.instr_valid), 32'd0);
    check32("t6_req_valid_drop", 32'(bus.imem_req_valid), 32'd0);
    check32("t6_req_addr", bus.imem_req_addr, 32'h0);
    sample_edge();
    advance();
    rst = 1'b0;
    model_reset();
    bus.imem_req_ready = 1'b0;
    repeat (4) tick();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    wait_got("t6_timeout", 2, 40);
    exp_q = '{32'h0, 32'h4};
    compare_got("t6_refetch");

    // randomized traffic against the reference model
    do_reset(1'b0);
    for (int c = 0; c < 1500; c++) begin
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.instr_ready    = ($urandom_range(0, 3) != 0);
      lat                = $urandom_range(1, 4);
      if ($urandom_range(0, 19) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom);
      end
      tick();
    end
    check32("rand_progress", 32'(got_q.size() > 100), 32'd1);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
